// File: rtl/ram_burst_master_if.sv
// Requester-side handshake bundle for ram_burst_master: command, write-beat and read-beat streams.
interface ram_burst_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;

  // Requester (processing datapath) view
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  // Burst master view
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst read/write initiator for a single-port synchronous RAM with 1-cycle read latency.
// Optional XOR checksum of all transferred beats when RAM_MST_CHECKSUM_EN is defined.
module ram_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_master_if.slave     bus,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef RAM_MST_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] rd_csum
`endif
);

  localparam int unsigned OCC_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  inflight;

  logic [1:0]            buf_cnt;
  logic                  buf_wp;
  logic                  buf_rp;
  logic [DATA_WIDTH-1:0] skid [2];

  logic                  cmd_hs;
  logic                  wr_beat;
  logic                  rd_valid_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  rd_pop;
  logic                  rd_issue;
  logic                  skid_push;
  logic                  skid_pop;
  logic                  last_beat;
  logic [OCC_WIDTH-1:0]  occupancy;

  // Handshake and credit decode
  always_comb begin
    cmd_hs     = bus.cmd_valid && (state == IDLE);
    wr_beat    = bus.wr_valid && (state == WRITE);
    last_beat  = (beat_cnt == '0);
    rd_valid_c = (buf_cnt != 2'd0) || inflight;
    rd_data_c  = '0;
    if (buf_cnt != 2'd0) begin
      rd_data_c = skid[buf_rp];
    end else if (inflight) begin
      rd_data_c = ram_q;
    end
    rd_pop     = rd_valid_c && bus.rd_ready;
    occupancy  = OCC_WIDTH'(buf_cnt) + OCC_WIDTH'(inflight);
    // Entries plus in-flight, net of this cycle's pop, must stay below two
    rd_issue   = (state == READ) && (occupancy < (OCC_WIDTH'(2) + OCC_WIDTH'(rd_pop)));
    // Arriving word bypasses the skid only when the skid is empty and it is consumed now
    skid_push  = inflight && !((buf_cnt == 2'd0) && rd_pop);
    skid_pop   = rd_pop && (buf_cnt != 2'd0);
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = rd_valid_c;
  assign bus.rd_data   = rd_data_c;
  assign busy          = (state != IDLE);
  assign ram_we        = wr_beat;
  assign ram_addr      = addr_cnt;
  assign ram_d         = (state == WRITE) ? bus.wr_data : '0;

  // Burst sequencing: address/beat counters and state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            addr_cnt <= bus.cmd_addr;
            beat_cnt <= bus.cmd_len;
            state    <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            if (last_beat) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_pop && (occupancy == OCC_WIDTH'(1))) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid occupancy and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      buf_wp  <= 1'b0;
      buf_rp  <= 1'b0;
    end else begin
      if (skid_push) begin
        buf_wp <= ~buf_wp;
      end
      if (skid_pop) begin
        buf_rp <= ~buf_rp;
      end
      buf_cnt <= buf_cnt + 2'(skid_push) - 2'(skid_pop);
    end
  end

  // Skid storage needs no reset; occupancy qualifies it
  always_ff @(posedge clk) begin
    if (skid_push) begin
      skid[buf_wp] <= ram_q;
    end
  end

`ifdef RAM_MST_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  // XOR of every read beat delivered and every write beat accepted in the current burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (cmd_hs) begin
      csum <= '0;
    end else if (rd_pop) begin
      csum <= csum ^ rd_data_c;
    end else if (wr_beat) begin
      csum <= csum ^ bus.wr_data;
    end
  end

  assign rd_csum = csum;
`endif

endmodule
